dmem_master: RTL and testbench
==============================

// Module: dmem_master
// PURPOSE
//   Initiator side of the data-memory port: accepts one load/store at a time from the CPU
//   core (req/ready, valid response) and drives the 32k x 48 data memory strobe interface.
//   Forms the effective address as (base + index) mod 2^15. Emits each read/write strobe
//   as a one-cycle pulse and waits for done. Word 0 reads as zero. A watchdog flags a lost done.
// PARAMETERS
//   TIMEOUT     15  WAIT-state cycles without i_done before the access is aborted (1..255)
//   ZERO_WORD0  1   1: address 0 is hardwired zero (no memory cycle); 0: normal access
// PORTS
//   clk       in   1   clock, all state on rising edge
//   reset     in   1   asynchronous, active-high reset
//   i_req     in   1   CPU request; accepted on a clock edge where i_req & o_ready
//   i_we      in   1   1 = store, 0 = load (sampled with i_req)
//   i_base    in   15  executive address (sampled with i_req)
//   i_index   in   15  index-register value (sampled with i_req)
//   i_wdata   in   48  store data (sampled with i_req)
//   o_ready   out  1   block idle, can accept a request
//   o_valid   out  1   one-cycle pulse: access finished (load data or store ack)
//   o_rdata   out  48  load result, held until next o_valid
//   o_error   out  1   one-cycle pulse with o_valid: watchdog abort
//   o_addr    out  15  memory address, registered
//   o_read    out  1   memory read strobe, one-cycle pulse
//   o_write   out  1   memory write strobe, one-cycle pulse
//   o_data    out  48  memory write data, registered
//   i_data    in   48  memory read data, valid in the cycle i_done is high
//   i_done    in   1   memory completion, one cycle after the strobe cycle
// BEHAVIOUR
//   Reset (async): state IDLE; o_ready=1; o_valid, o_error, o_read, o_write=0;
//   o_addr=0, o_data=0, o_rdata=0, watchdog=0. Strobes drop immediately on reset assertion.
//   States: IDLE -> ISSUE -> WAIT -> IDLE; IDLE -> ZERO -> IDLE for word-0 shortcut.
//   IDLE: o_ready=1. On i_req: o_addr <= i_base+i_index (15-bit, carry dropped), latch i_we,
//     o_data <= i_wdata; go ISSUE (or ZERO if ZERO_WORD0 and sum==0).
//   ISSUE: o_read=!we / o_write=we for exactly this cycle; watchdog cleared; go WAIT.
//   WAIT: i_done=1 -> o_valid=1 next cycle, o_rdata <= i_data on load (unchanged on store),
//     go IDLE. Else watchdog++; at watchdog==TIMEOUT -> o_valid=1 and o_error=1 next cycle,
//     o_rdata unchanged, go IDLE.
//   ZERO: no strobe; load -> o_rdata <= 0; store discarded; o_valid=1 next cycle; go IDLE.
//   Latency: req edge E0; strobe in cycle 1; i_done in cycle 2; o_valid in cycle 3 with
//     o_ready already 1 -> new request may be accepted at end of cycle 3 (1 access / 3 clk).
//   ZERO latency: o_valid in cycle 2.
//   o_ready=0 in ISSUE, WAIT, ZERO; i_req there is ignored, not queued.
//   i_done outside WAIT (stray, or after reset/abort) is ignored; never produces o_valid.
//   Never assert o_read and o_write together; never hold a strobe two cycles.
//   Reset mid-access: no o_valid for the aborted access; a memory write already strobed
//     may complete in memory (not rolled back).
// STRUCTURE
//   Shared package dmem_pkg: DADDR_W=15, DWORD_W=48, enum state_t {IDLE,ISSUE,WAIT,ZERO}.
//   Sub-module dmem_watchdog: clear/enable/count, 8-bit, output expired at ==TIMEOUT.
//   Address adder and FSM stay in dmem_master.
// TESTING (bench with dmemory model plus injectable done-suppression)
//   Store base=0x0010 idx=0x0005 data=48'h123456789ABC, then load same -> o_write one pulse
//     at o_addr=0x0015; load o_valid in cycle 3, o_rdata=48'h123456789ABC, o_error=0.
//   Wrap: base=0x7FFF idx=0x0002 load -> o_addr=0x0001; sum 0x7FFF+0x0001 -> word 0 path.
//   Word 0 (ZERO_WORD0=1): store 48'hFFFF_FFFF_FFFF to addr 0 -> no o_write; load -> no o_read,
//     o_rdata=0, o_valid in cycle 2. With ZERO_WORD0=0 the memory is accessed normally.
//   Timeout: suppress i_done, load -> o_valid & o_error on the cycle after TIMEOUT=15
//     WAIT cycles, o_rdata unchanged; late i_done afterwards ignored.
//   Back-to-back: i_req held high for 4 loads -> o_valid every 3 cycles, one strobe each,
//     o_ready low exactly in ISSUE/WAIT cycles.
//   Reset asserted during WAIT -> strobes/o_valid/o_error 0 at once; after release o_ready=1,
//     following i_done ignored, next request completes normally.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and widths for the data-memory initiator.
// Imported by the interface, the watchdog and the master FSM.
package dmem_pkg;

    localparam int DADDR_W = 15;
    localparam int DWORD_W = 48;
    localparam int WDOG_W  = 8;

    typedef logic [DADDR_W-1:0] daddr_t;
    typedef logic [DWORD_W-1:0] dword_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        ZERO
    } state_t;

    // Effective address: base plus index, carry out of bit 14 dropped.
    function automatic daddr_t eff_addr(input daddr_t base, input daddr_t index);
        return base + index;
    endfunction

endpackage

// File: rtl/dmem_master_if.sv
// CPU request/response and memory strobe bundle of the data-memory port.
// master = the initiator block, slave = whoever sits on the other side.
interface dmem_master_if;
    import dmem_pkg::*;

    logic   i_req;
    logic   i_we;
    daddr_t i_base;
    daddr_t i_index;
    dword_t i_wdata;
    logic   o_ready;
    logic   o_valid;
    dword_t o_rdata;
    logic   o_error;

    daddr_t o_addr;
    logic   o_read;
    logic   o_write;
    dword_t o_data;
    dword_t i_data;
    logic   i_done;

    modport master (
        input  i_req, i_we, i_base, i_index, i_wdata,
        output o_ready, o_valid, o_rdata, o_error,
        output o_addr, o_read, o_write, o_data,
        input  i_data, i_done
    );

    modport slave (
        output i_req, i_we, i_base, i_index, i_wdata,
        input  o_ready, o_valid, o_rdata, o_error,
        input  o_addr, o_read, o_write, o_data,
        output i_data, i_done
    );

endinterface

// File: rtl/dmem_watchdog.sv
// Counts WAIT cycles without a memory completion.
// Expired flags the enabled cycle that brings the count to TIMEOUT.
module dmem_watchdog
    import dmem_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_en,
    output logic o_expired
);

    logic [WDOG_W-1:0] r_count;
    logic [WDOG_W-1:0] w_next;
    logic [WDOG_W-1:0] w_limit;

    assign w_next    = r_count + 1'b1;
    assign w_limit   = WDOG_W'(TIMEOUT);
    assign o_expired = i_en && (w_next == w_limit);

    // Counter: cleared on a fresh strobe, advanced while still waiting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= w_next;
        end
    end

endmodule

// File: rtl/dmem_master.sv
// Initiator side of the data-memory port: one load/store at a time,
// one-cycle strobes, word-0 shortcut and a watchdog on lost completions.
module dmem_master
    import dmem_pkg::*;
#(
    parameter int unsigned TIMEOUT    = 15,
    parameter bit          ZERO_WORD0 = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    dmem_master_if.master bus
);

    state_t r_state;
    logic   r_ready;
    logic   r_valid;
    logic   r_error;
    logic   r_read;
    logic   r_write;
    logic   r_we;
    daddr_t r_addr;
    dword_t r_data;
    dword_t r_rdata;

    daddr_t w_ea;
    logic   w_ea_zero;
    logic   w_wd_clear;
    logic   w_wd_en;
    logic   w_expired;

    assign w_ea       = eff_addr(bus.i_base, bus.i_index);
    assign w_ea_zero  = ZERO_WORD0 && (w_ea == '0);
    assign w_wd_clear = (r_state == ISSUE);
    assign w_wd_en    = (r_state == WAIT) && !bus.i_done;

    dmem_watchdog #(
        .TIMEOUT   (TIMEOUT)
    ) u_wdog (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (w_wd_clear),
        .i_en      (w_wd_en),
        .o_expired (w_expired)
    );

    // Access sequencer; every output is a register so strobes are glitch-free.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_ready <= 1'b1;
            r_valid <= 1'b0;
            r_error <= 1'b0;
            r_read  <= 1'b0;
            r_write <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
            r_rdata <= '0;
        end else begin
            r_valid <= 1'b0;
            r_error <= 1'b0;
            r_read  <= 1'b0;
            r_write <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (bus.i_req) begin
                        r_addr  <= w_ea;
                        r_data  <= bus.i_wdata;
                        r_we    <= bus.i_we;
                        r_ready <= 1'b0;
                        if (w_ea_zero) begin
                            r_state <= ZERO;
                        end else begin
                            r_state <= ISSUE;
                            r_read  <= !bus.i_we;
                            r_write <= bus.i_we;
                        end
                    end
                end
                ISSUE: begin
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (bus.i_done) begin
                        r_valid <= 1'b1;
                        r_ready <= 1'b1;
                        r_state <= IDLE;
                        if (!r_we) begin
                            r_rdata <= bus.i_data;
                        end
                    end else if (w_expired) begin
                        r_valid <= 1'b1;
                        r_error <= 1'b1;
                        r_ready <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                ZERO: begin
                    r_valid <= 1'b1;
                    r_ready <= 1'b1;
                    r_state <= IDLE;
                    if (!r_we) begin
                        r_rdata <= '0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign bus.o_ready = r_ready;
    assign bus.o_valid = r_valid;
    assign bus.o_error = r_error;
    assign bus.o_rdata = r_rdata;
    assign bus.o_addr  = r_addr;
    assign bus.o_read  = r_read;
    assign bus.o_write = r_write;
    assign bus.o_data  = r_data;

endmodule

// File: tb/tb_dmem_master.sv
// Randomised and directed checks of dmem_master against a word-level
// memory reference; a second instance covers ZERO_WORD0=0.
module tb_dmem_master;

    localparam int TMO = 15;

    logic clk;
    logic reset;

    dmem_master_if ifm ();
    dmem_master_if if1 ();

    dmem_master #(
        .TIMEOUT    (TMO),
        .ZERO_WORD0 (1'b1)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifm.master)
    );

    dmem_master #(
        .TIMEOUT    (TMO),
        .ZERO_WORD0 (1'b0)
    ) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (if1.master)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference: what memory should hold and what o_rdata should show.
    logic [47:0] ref_mem [int];
    logic [47:0] ref_rd;

    // Device model behind instance 0.
    logic [47:0] dev_mem [int];
    bit          supp  = 0;
    bit          stray = 0;
    bit          pend  = 0;
    logic [47:0] pend_data;

    // Device model behind instance 1 (only word 0 used).
    logic [47:0] m1 = '0;
    bit          pend1 = 0;
    logic [47:0] pd1;
    int          rd1 = 0;
    int          wr1 = 0;

    // Strobe / response monitor counters for instance 0.
    int  rd_cnt = 0;
    int  wr_cnt = 0;
    int  both_cnt = 0;
    int  dbl_cnt = 0;
    int  vcnt = 0;
    bit  prev_strobe = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // Memory responds with i_done one cycle after the strobe cycle.
    always begin
        @(posedge clk);
        #1;
        ifm.i_done = 1'b0;
        if (pend) begin
            ifm.i_done = 1'b1;
            ifm.i_data = pend_data;
            pend = 0;
        end else if (stray) begin
            ifm.i_done = 1'b1;
            ifm.i_data = 48'hDEAD_BEEF_0BAD;
            stray = 0;
        end
        if (ifm.o_read || ifm.o_write) begin
            if (ifm.o_write) dev_mem[int'(ifm.o_addr)] = ifm.o_data;
            pend_data = dev_mem.exists(int'(ifm.o_addr)) ? dev_mem[int'(ifm.o_addr)] : 48'h0;
            pend = !supp;
        end
    end

    always begin
        @(posedge clk);
        #1;
        if1.i_done = pend1;
        if1.i_data = pd1;
        pend1 = 0;
        if (if1.o_read) rd1++;
        if (if1.o_write) begin
            wr1++;
            m1 = if1.o_data;
        end
        if (if1.o_read || if1.o_write) begin
            pd1 = m1;
            pend1 = 1;
        end
    end

    always @(negedge clk) begin
        if (ifm.o_read) rd_cnt++;
        if (ifm.o_write) wr_cnt++;
        if (ifm.o_read && ifm.o_write) both_cnt++;
        if ((ifm.o_read || ifm.o_write) && prev_strobe) dbl_cnt++;
        prev_strobe = ifm.o_read || ifm.o_write;
        if (ifm.o_valid) vcnt++;
    end

    // One access on instance 0; entered and left #1 after a rising edge.
    task automatic xact(input bit we, input logic [14:0] base, input logic [14:0] idx,
                        input logic [47:0] wd, input bit sup);
        int ea;
        int lat;
        int c;
        int rlow;
        int r0;
        int w0;
        bit zero;
        logic [47:0] exp_rd;
        ea = (int'(base) + int'(idx)) % 32768;
        zero = (ea == 0);
        lat = zero ? 2 : (sup ? TMO + 2 : 3);
        exp_rd = ref_rd;
        if (!we && zero) exp_rd = 48'h0;
        else if (!we && !sup) exp_rd = ref_mem.exists(ea) ? ref_mem[ea] : 48'h0;
        if (we && !zero) ref_mem[ea] = wd;
        ref_rd = exp_rd;
        supp = sup;
        r0 = rd_cnt;
        w0 = wr_cnt;
        check("idle_ready", 64'(ifm.o_ready), 64'd1);
        ifm.i_req = 1'b1;
        ifm.i_we = we;
        ifm.i_base = base;
        ifm.i_index = idx;
        ifm.i_wdata = wd;
        @(posedge clk);
        #1;
        ifm.i_req = 1'b0;
        ifm.i_wdata = ~wd;
        c = 1;
        rlow = 0;
        while (!ifm.o_valid && c < 40) begin
            if (!ifm.o_ready) rlow++;
            @(posedge clk);
            #1;
            c++;
        end
        supp = 0;
        check("latency", 64'(c), 64'(lat));
        check("busy_cycles", 64'(rlow), 64'(lat - 1));
        check("valid_ready", 64'(ifm.o_ready), 64'd1);
        check("rdata", 64'(ifm.o_rdata), 64'(exp_rd));
        check("error", 64'(ifm.o_error), 64'(sup && !zero));
        check("addr", 64'(ifm.o_addr), 64'(ea));
        check("reads", 64'(rd_cnt - r0), 64'(!zero && !we));
        check("writes", 64'(wr_cnt - w0), 64'(!zero && we));
    endtask

    task automatic xact1(input bit we, input logic [47:0] wd,
                         output int lat, output logic [47:0] rd);
        if1.i_req = 1'b1;
        if1.i_we = we;
        if1.i_base = '0;
        if1.i_index = '0;
        if1.i_wdata = wd;
        @(posedge clk);
        #1;
        if1.i_req = 1'b0;
        lat = 1;
        while (!if1.o_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        rd = if1.o_rdata;
    endtask

    task automatic b2b();
        logic [12:0] vmask;
        logic [47:0] exp_rd;
        int rlow;
        int r0;
        exp_rd = ref_mem.exists(32'h123) ? ref_mem[32'h123] : 48'h0;
        vmask = '0;
        rlow = 0;
        r0 = rd_cnt;
        ifm.i_req = 1'b1;
        ifm.i_we = 1'b0;
        ifm.i_base = 15'h0100;
        ifm.i_index = 15'h0023;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk);
            #1;
            if (c == 12) ifm.i_req = 1'b0;
            if (ifm.o_valid) begin
                vmask[c] = 1'b1;
                check("b2b_rdata", 64'(ifm.o_rdata), 64'(exp_rd));
            end
            if (!ifm.o_ready) rlow++;
        end
        ref_rd = exp_rd;
        check("b2b_valid_mask", 64'(vmask), 64'h1248);
        check("b2b_busy", 64'(rlow), 64'd8);
        check("b2b_reads", 64'(rd_cnt - r0), 64'd4);
    endtask

    // Reset hits access cycle 'at' (1 = strobe cycle, 2 = first wait cycle).
    task automatic rst_mid(input int at);
        int v0;
        supp = 1;
        ifm.i_req = 1'b1;
        ifm.i_we = 1'b0;
        ifm.i_base = 15'h0040;
        ifm.i_index = 15'h0000;
        @(posedge clk);
        #1;
        ifm.i_req = 1'b0;
        for (int c = 1; c < at; c++) begin
            @(posedge clk);
            #1;
        end
        check("pre_rst_busy", 64'(ifm.o_ready), 64'd0);
        check("pre_rst_strobe", 64'(ifm.o_read), 64'(at == 1));
        reset = 1'b1;
        #1;
        check("rst_outs", 64'({ifm.o_read, ifm.o_write, ifm.o_valid, ifm.o_error}), 64'd0);
        check("rst_ready", 64'(ifm.o_ready), 64'd1);
        v0 = vcnt;
        @(posedge clk);
        #1;
        reset = 1'b0;
        supp = 0;
        stray = 1;
        repeat (4) @(posedge clk);
        #1;
        check("rst_no_valid", 64'(vcnt - v0), 64'd0);
        ref_rd = '0;
    endtask

    initial begin
        int lat;
        int v0;
        logic [47:0] rd;
        logic [14:0] b;
        int tgt;
        reset = 1'b1;
        ifm.i_req = 1'b0;
        ifm.i_we = 1'b0;
        ifm.i_base = '0;
        ifm.i_index = '0;
        ifm.i_wdata = '0;
        ifm.i_data = '0;
        ifm.i_done = 1'b0;
        if1.i_req = 1'b0;
        if1.i_we = 1'b0;
        if1.i_base = '0;
        if1.i_index = '0;
        if1.i_wdata = '0;
        if1.i_data = '0;
        if1.i_done = 1'b0;
        ref_rd = '0;
        #2;
        check("rst_ready0", 64'(ifm.o_ready), 64'd1);
        check("rst_ctl0", 64'({ifm.o_valid, ifm.o_error, ifm.o_read, ifm.o_write}), 64'd0);
        check("rst_addr0", 64'(ifm.o_addr), 64'd0);
        check("rst_data0", 64'(ifm.o_data), 64'd0);
        check("rst_rdata0", 64'(ifm.o_rdata), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        xact(1'b1, 15'h0010, 15'h0005, 48'h1234_5678_9ABC, 1'b0);
        xact(1'b0, 15'h0010, 15'h0005, 48'h0, 1'b0);
        xact(1'b1, 15'h0001, 15'h0000, 48'h0000_CAFE_F00D, 1'b0);
        xact(1'b0, 15'h7FFF, 15'h0002, 48'h0, 1'b0);
        xact(1'b1, 15'h0000, 15'h0000, 48'hFFFF_FFFF_FFFF, 1'b0);
        xact(1'b0, 15'h7FFF, 15'h0001, 48'h0, 1'b0);
        xact(1'b0, 15'h0010, 15'h0005, 48'h0, 1'b0);

        xact(1'b0, 15'h0001, 15'h0000, 48'h0, 1'b1);
        @(posedge clk);
        #1;
        v0 = vcnt;
        stray = 1;
        repeat (3) @(posedge clk);
        #1;
        check("late_done_ignored", 64'(vcnt - v0), 64'd0);

        b2b();
        rst_mid(1);
        xact(1'b0, 15'h0010, 15'h0005, 48'h0, 1'b0);
        rst_mid(2);
        xact(1'b0, 15'h0001, 15'h0000, 48'h0, 1'b0);

        for (int i = 0; i < 80; i++) begin
            b = 15'($urandom);
            tgt = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 32767)) : int'($urandom_range(0, 5));
            xact(1'($urandom), b, 15'(tgt - int'(b)),
                 {16'($urandom), 32'($urandom)}, $urandom_range(0, 9) == 0);
        end

        xact1(1'b1, 48'hFFFF_FFFF_FFFF, lat, rd);
        check("zw0_store_lat", 64'(lat), 64'd3);
        check("zw0_store_strobe", 64'(wr1), 64'd1);
        xact1(1'b0, 48'h0, lat, rd);
        check("zw0_load_lat", 64'(lat), 64'd3);
        check("zw0_load_strobe", 64'(rd1), 64'd1);
        check("zw0_load_data", 64'(rd), 64'hFFFF_FFFF_FFFF);

        check("strobe_overlap", 64'(both_cnt), 64'd0);
        check("strobe_double", 64'(dbl_cnt), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
